// File: rtl/sw_responder_if.sv
// Status and control bundle of the single-wire responder; the pad wire itself stays a plain inout.
// master = host logic that sets ack_en and consumes received bytes; slave = the responder.
interface sw_responder_if;
    logic       ack_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frm_err;
    logic       line_oe;
    logic       busy;

    modport master (
        output ack_en,
        input  rx_data,
        input  rx_valid,
        input  frm_err,
        input  line_oe,
        input  busy
    );

    modport slave (
        input  ack_en,
        output rx_data,
        output rx_valid,
        output frm_err,
        output line_oe,
        output busy
    );
endinterface

// File: rtl/sw_responder.sv
// Single-wire half-duplex responder: receives a UART-style byte, then answers with a one-bit-period low ACK.
// Latency: rx_valid one cycle after the stop sample, plus 2 cycles of input sync; no backpressure.
module sw_responder #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TURN_CYCLES  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    inout  wire             line,
    sw_responder_if.slave   bus
);

    localparam int CMAX = (CLKS_PER_BIT > TURN_CYCLES) ? CLKS_PER_BIT : TURN_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK,
        TURN,
        ACK
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            frm_err_q;
    logic            line_oe_q;
    logic            sync1;
    logic            sync2;
    logic            line_s;

    assign line   = line_oe_q ? 1'b0 : 1'bz;
    assign line_s = sync2;

    // Our own ACK is masked out of the synchronizer so the low we drive
    // can never be mistaken for an initiator start bit once IDLE resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= line_oe_q ? 1'b1 : line;
            sync2 <= line_oe_q ? 1'b1 : sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            frm_err_q  <= 1'b0;
            line_oe_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            frm_err_q  <= 1'b0;
            cnt        <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!line_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= line_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= line_s;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (line_s) begin
                            rx_data_q  <= shreg;
                            rx_valid_q <= 1'b1;
                            state      <= bus.ack_en ? TURN : IDLE;
                        end else begin
                            frm_err_q <= 1'b1;
                            state     <= BRK;
                        end
                    end
                end
                BRK: begin
                    // A line stuck low must return high before reception can restart.
                    cnt <= '0;
                    if (line_s) begin
                        state <= IDLE;
                    end
                end
                TURN: begin
                    if (cnt == TURN_LAST) begin
                        cnt       <= '0;
                        line_oe_q <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        line_oe_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cnt       <= '0;
                    line_oe_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.frm_err  = frm_err_q;
    assign bus.line_oe  = line_oe_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_sw_responder.sv
// Bench for sw_responder: an initiator model drives frames on the pulled-up wire, a scoreboard checks bytes and ACK shape.
module tb_sw_responder;

    localparam int CPB  = 8;
    localparam int TURN = 4;

    logic clk;
    logic rst_n;
    logic init_low;
    wire  line;

    sw_responder_if bus ();

    pullup (line);
    assign line = init_low ? 1'b0 : 1'bz;

    sw_responder #(
        .CLKS_PER_BIT (CPB),
        .TURN_CYCLES  (TURN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (line),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         n_vld    = 0;
    int         n_err    = 0;
    int         n_ack    = 0;
    int         since    = 1000;
    int         run      = 0;
    logic       prev_oe  = 1'b0;
    logic       ack_abort = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_ok);
        init_low = 1'b1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            init_low = ~data[i];
            repeat (CPB) @(negedge clk);
        end
        init_low = ~stop_ok;
        repeat (CPB) @(negedge clk);
        if (stop_ok) init_low = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 300 && bus.busy !== 1'b0; i++) @(negedge clk);
        check(tag, bus.busy, 1'b0);
    endtask

    task automatic wait_oe(input string tag, input logic val);
        int i;
        for (i = 0; i < 300 && bus.line_oe !== val; i++) @(negedge clk);
        check(tag, bus.line_oe, val);
    endtask

    // Scoreboard / protocol monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rx_valid) since = 0;
            else since++;
            if (bus.rx_valid || bus.frm_err) check("excl", bus.rx_valid & bus.frm_err, 1'b0);
            if (bus.rx_valid) begin
                n_vld++;
                check("rx_queue", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("rx_data", bus.rx_data, exp_q.pop_front());
            end
            if (bus.frm_err) n_err++;
            if (bus.line_oe && !prev_oe) begin
                n_ack++;
                run = 0;
                check("ack_gap", since, TURN);
                check("ack_line", line, 1'b0);
            end
            if (bus.line_oe) run++;
            if (!bus.line_oe && prev_oe) begin
                if (ack_abort) ack_abort = 1'b0;
                else check("ack_len", run, CPB);
            end
            prev_oe = bus.line_oe;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_before;
        rst_n      = 1'b0;
        init_low   = 1'b0;
        bus.ack_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_frm_err", bus.frm_err, 1'b0);
        check("rst_line_oe", bus.line_oe, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_line", line, 1'b1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic frame with ACK.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_idle("idle_a5");
        check("a5_data", bus.rx_data, 8'hA5);
        check("a5_ack_cnt", n_ack, 1);
        check("a5_line", line, 1'b1);

        // Short glitch must be rejected in START.
        init_low = 1'b1;
        repeat (2) @(negedge clk);
        init_low = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy", bus.busy, 1'b0);
        check("glitch_vld", n_vld, 1);
        check("glitch_err", n_err, 0);
        check("glitch_data", bus.rx_data, 8'hA5);

        // Stop bit low, line held low afterwards.
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        check("brk_busy", bus.busy, 1'b1);
        init_low = 1'b0;
        wait_idle("idle_brk");
        check("brk_err", n_err, 1);
        check("brk_vld", n_vld, 1);
        check("brk_data", bus.rx_data, 8'hA5);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_idle("idle_81");
        check("data_81", bus.rx_data, 8'h81);

        // ack_en low: byte received, no ACK.
        bus.ack_en = 1'b0;
        ack_before = n_ack;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        wait_idle("idle_ff");
        repeat (20) @(negedge clk);
        check("ff_data", bus.rx_data, 8'hFF);
        check("ff_no_ack", n_ack, ack_before);
        bus.ack_en = 1'b1;

        // Reset in the 3rd ACK cycle.
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_oe("wait_ack_55", 1'b1);
        repeat (2) @(negedge clk);
        ack_abort = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_oe", bus.line_oe, 1'b0);
        check("mid_rst_line", line, 1'b1);
        check("mid_rst_data", bus.rx_data, 8'h00);
        check("mid_rst_vld", bus.rx_valid, 1'b0);
        check("mid_rst_err", bus.frm_err, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        wait_idle("idle_00");
        check("data_00", bus.rx_data, 8'h00);

        // Back-to-back frames, second starting on the first IDLE cycle after ACK.
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_frame(8'h12, 1'b1);
        wait_oe("b2b_ack_on", 1'b1);
        wait_oe("b2b_ack_off", 1'b0);
        send_frame(8'h34, 1'b1);
        wait_idle("idle_34");
        repeat (5) @(negedge clk);
        check("data_34", bus.rx_data, 8'h34);

        check("final_queue", exp_q.size(), 0);
        check("final_vld", n_vld, 7);
        check("final_err", n_err, 1);
        check("final_ack", n_ack, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sw_responder.md
# sw_responder

Single-wire, half-duplex bus responder. It receives UART-style byte frames from a remote initiator on a shared tristate line, then turns the line around and drives a one-bit-period ACK pulse back on the same wire. The line is idle-high, held there by an external pull-up. The block sits at the pad boundary and contains its own tristate driver, so `line` is the only pad-facing port.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period. Must be even and ≥4.
- `TURN_CYCLES`, default 4: cycles the line stays released between the end of the stop bit and the start of ACK. Must be ≥1.
- `clk`  input  1: single clock; all state is on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `line`  inout  1: shared bus wire. Driven only as `line_oe ? 1'b0 : 1'bz`.
- `ack_en`  input  1: 1 = ACK received frames; 0 = stay silent (NAK by absence). Sampled in STOP.
- `rx_data`  output  8: last good byte, LSB first on the wire. Holds its value until the next good frame.
- `rx_valid`  output  1: one-cycle pulse when `rx_data` updates.
- `frm_err`  output  1: one-cycle pulse on a framing error (stop bit low).
- `line_oe`  output  1: 1 while this block drives the line low (ACK). Exported for debug.
- `busy`  output  1: 1 in any state other than IDLE.

## Operation
- Input path: `line` goes through a 2-flop synchronizer to give `line_s`. All decisions use `line_s`.
- Counter `cnt` resets to 0 on every state entry and increments each cycle.
- States and transitions:
  - IDLE: when `line_s` is 0 (low level seen), go to START.
  - START: at `cnt == CLKS_PER_BIT/2-1`, sample `line_s`. If 0, go to DATA (bit index 0). If 1 (glitch), go to IDLE with no pulses.
  - DATA: at `cnt == CLKS_PER_BIT-1`, sample `line_s` into shift register bit [index] and restart `cnt`. After the 8th sample, go to STOP.
  - STOP: at `cnt == CLKS_PER_BIT-1`, sample `line_s`.
    - If 1: load `rx_data`, pulse `rx_valid`. Then go to TURN if `ack_en` = 1, else IDLE.
    - If 0: pulse `frm_err`, leave `rx_data` unchanged, go to BRK.
  - BRK: wait for `line_s == 1`, then go to IDLE. A held-low line never restarts reception.
  - TURN: line released. At `cnt == TURN_CYCLES-1`, go to ACK.
  - ACK: `line_oe` = 1 for exactly `CLKS_PER_BIT` cycles, then go to IDLE with the line released.
- `line_oe` is a registered output: high exactly during ACK cycles, never in any other state.
- The block never samples its own ACK as a start bit. In IDLE, the line is already released, and the pull-up restores high before the next initiator frame; that gap is the initiator's responsibility.
- `ack_en` changes outside STOP have no effect on the frame in progress.

## Timing
- Reset values: `rx_data` = 8'h00, `rx_valid` = 0, `frm_err` = 0, `line_oe` = 0 (line at Z), `busy` = 0, state = IDLE, synchronizer flops = 1.
- Reset is asynchronous, including mid-ACK: `line_oe` drops and the line releases without waiting for a clock. After reset deasserts, a fresh start bit is required.
- Input latency: 2 cycles from the pad to `line_s`.
- Sample points: mid-bit, at start-edge + `CLKS_PER_BIT/2` + n·`CLKS_PER_BIT` (in `line_s` time) for n = 1..8 (data) and n = 9 (stop).
- `rx_valid` and `frm_err` assert in the cycle after the stop sample edge. They are mutually exclusive and are never asserted together.
- ACK timing: `line_oe` rises `TURN_CYCLES` cycles after the `rx_valid` pulse and stays high for exactly `CLKS_PER_BIT` cycles.
- Back-to-back: a new start bit is accepted from the first IDLE cycle after ACK, or after STOP when `ack_en` = 0.

## Test plan
- `CLKS_PER_BIT` = 8, `TURN_CYCLES` = 4, `ack_en` = 1. Initiator sends 0xA5 → `rx_data` = 0xA5; `rx_valid` high for 1 cycle; line released for 4 cycles, then low for exactly 8 cycles, then Z; `busy` falls afterwards.
- Initiator pulls the line low for 2 cycles only → no `rx_valid`, no `frm_err`; state returns to IDLE after START; `rx_data` unchanged.
- Frame 0x3C sent with stop bit forced low and the line held low for 40 cycles → `frm_err` pulses once; no `rx_valid`; `rx_data` keeps its previous value; the next valid frame 0x81 (sent after the line goes high) gives `rx_data` = 0x81.
- `ack_en` = 0, frame 0xFF → `rx_valid` pulses with `rx_data` = 0xFF; `line_oe` stays 0 for the whole frame and after.
- Assert `rst_n` = 0 in the 3rd cycle of ACK → `line_oe` = 0 and line at Z in the same timestep; all outputs at reset values; after release, frame 0x00 is received correctly.
- Two frames (0x12, 0x34) sent back-to-back with minimum spacing after ACK → two `rx_valid` pulses with 0x12 then 0x34, and two ACK pulses.
